// File: rtl/keypad_digit_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce; one number_valid strobe per press.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_digit_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] number,
  output logic       number_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_param_check
    $error("keypad_digit_scanner: illegal parameter value");
  end

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'hE;
      4'b1101: code = 4'h0;
      4'b1110: code = 4'hF;
      4'b1111: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_sync;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [3:0]    r_col_out;
  logic [1:0]    r_hits;
  logic [3:0]    r_code;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic [3:0]    r_number;
  logic          r_number_valid;
  logic          r_key_held;

  logic          w_sample;
  logic          w_frame_end;
  logic [3:0]    w_row_low;
  logic [2:0]    w_col_cnt;
  logic [3:0]    w_col_code;
  logic [2:0]    w_sum;
  logic [1:0]    w_hits_tot;
  logic [3:0]    w_frame_code;
  logic          w_none;
  logic          w_single;
  logic [CW-1:0] w_cnt_next;
  logic          w_rep_fire;

  assign w_sample    = (r_dwell == DWELL_LAST);
  assign w_frame_end = w_sample && (r_col == 2'd3);
  assign w_none      = (w_hits_tot == 2'd0);
  assign w_single    = (w_hits_tot == 2'd1);
  assign w_cnt_next  = (r_cnt == CNT_DONE) ? r_cnt : r_cnt + CW'(1);

  // Classify the current column sample and merge it with the frame so far (hit count saturates at 2).
  always_comb begin
    w_row_low = ~r_row_sync;
    w_col_cnt = popcount4(w_row_low);
    if (w_row_low[0]) begin
      w_col_code = keymap(2'd0, r_col);
    end else if (w_row_low[1]) begin
      w_col_code = keymap(2'd1, r_col);
    end else if (w_row_low[2]) begin
      w_col_code = keymap(2'd2, r_col);
    end else if (w_row_low[3]) begin
      w_col_code = keymap(2'd3, r_col);
    end else begin
      w_col_code = 4'h0;
    end
    w_sum        = {1'b0, r_hits} + w_col_cnt;
    w_hits_tot   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_frame_code = (r_hits != 2'd0) ? r_code : w_col_code;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_FRAMES);

  logic [RW-1:0] r_rep;
  logic          w_rep_match;

  assign w_rep_match = (r_state == S_PRESSED) && w_single && (w_frame_code == r_number);
  assign w_rep_fire  = w_frame_end && w_rep_match && ((r_rep + RW'(1)) == REP_DONE);

  // Repeat counter only runs while the same single key stays down in PRESSED.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rep <= {RW{1'b0}};
    end else if (w_frame_end) begin
      if (w_rep_match && !w_rep_fire) begin
        r_rep <= r_rep + RW'(1);
      end else begin
        r_rep <= {RW{1'b0}};
      end
    end else begin
      r_rep <= r_rep;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Row synchroniser, column dwell/rotation and per-frame hit accumulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
      r_dwell    <= {DW{1'b0}};
      r_col      <= 2'd0;
      r_col_out  <= 4'b1110;
      r_hits     <= 2'd0;
      r_code     <= 4'h0;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
      if (w_sample) begin
        r_dwell   <= {DW{1'b0}};
        r_col     <= r_col + 2'd1;
        r_col_out <= {r_col_out[2:0], r_col_out[3]};
        if (w_frame_end) begin
          r_hits <= 2'd0;
          r_code <= 4'h0;
        end else begin
          r_hits <= w_hits_tot;
          r_code <= w_frame_code;
        end
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Press/release FSM, stepped once per frame end; outputs are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= {CW{1'b0}};
      r_cand         <= 4'h0;
      r_number       <= 4'h0;
      r_number_valid <= 1'b0;
      r_key_held     <= 1'b0;
    end else begin
      r_number_valid <= 1'b0;
      if (w_frame_end) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_frame_code;
              if (CNT_DONE == CNT_ONE) begin
                r_number       <= w_frame_code;
                r_number_valid <= 1'b1;
                r_key_held     <= 1'b1;
                r_cnt          <= {CW{1'b0}};
                r_state        <= S_PRESSED;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_DEBOUNCE: begin
            if (w_single && (w_frame_code == r_cand)) begin
              if (w_cnt_next == CNT_DONE) begin
                r_number       <= r_cand;
                r_number_valid <= 1'b1;
                r_key_held     <= 1'b1;
                r_cnt          <= {CW{1'b0}};
                r_state        <= S_PRESSED;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end else begin
              r_cnt   <= {CW{1'b0}};
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (w_none) begin
              if (CNT_DONE == CNT_ONE) begin
                r_key_held <= 1'b0;
                r_cnt      <= {CW{1'b0}};
                r_state    <= S_IDLE;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= S_RELEASE;
              end
            end else if (w_rep_fire) begin
              r_number_valid <= 1'b1;
            end else begin
              r_state <= S_PRESSED;
            end
          end
          S_RELEASE: begin
            if (w_none) begin
              if (w_cnt_next == CNT_DONE) begin
                r_key_held <= 1'b0;
                r_cnt      <= {CW{1'b0}};
                r_state    <= S_IDLE;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end else begin
              r_cnt   <= {CW{1'b0}};
              r_state <= S_PRESSED;
            end
          end
          default: begin
            r_cnt   <= {CW{1'b0}};
            r_state <= S_IDLE;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign col_out      = r_col_out;
  assign number       = r_number;
  assign number_valid = r_number_valid;
  assign key_held     = r_key_held;

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Directed bench for keypad_digit_scanner: keypad matrix model, expected-code scoreboard, strobe monitor.
module tb_keypad_digit_scanner;

  localparam logic [15:0] K_NONE = 16'h0000;
  localparam logic [15:0] K_1    = 16'h0001;
  localparam logic [15:0] K_2    = 16'h0002;
  localparam logic [15:0] K_4    = 16'h0010;
  localparam logic [15:0] K_5    = 16'h0020;
  localparam logic [15:0] K_7    = 16'h0100;
  localparam logic [15:0] K_8    = 16'h0200;
  localparam logic [15:0] K_9    = 16'h0400;
  localparam logic [15:0] K_0    = 16'h2000;
  localparam logic [15:0] K_HASH = 16'h4000;

  logic        clock;
  logic        reset_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  number;
  logic        number_valid;
  logic        key_held;

  logic [15:0] tb_keys;
  logic [3:0]  exp_q[$];
  int          checks;
  int          failures;
  int          strobes;
  int          strobes_before;
  int          exp_rep;

  keypad_digit_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2),
    .REPEAT_FRAMES   (3)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .row_in       (row_in),
    .col_out      (col_out),
    .number       (number),
    .number_valid (number_valid),
    .key_held     (key_held)
  );

  // Matrix model: bit r*4+c of tb_keys shorts row r to column c.
  assign row_in = {~|(tb_keys[15:12] & ~col_out), ~|(tb_keys[11:8] & ~col_out),
                   ~|(tb_keys[7:4] & ~col_out),   ~|(tb_keys[3:0] & ~col_out)};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold key set k for n frames; returns at the negedge just after each frame-end edge.
  task automatic frames(input logic [15:0] k, input int n);
    int w;
    tb_keys = k;
    for (int f = 0; f < n; f++) begin
      w = 0;
      while (col_out !== 4'b0111 && w < 40) begin
        @(negedge clock);
        w++;
      end
      while (col_out !== 4'b1110 && w < 40) begin
        @(negedge clock);
        w++;
      end
      chk("frame_timeout", {31'd0, (w >= 40)}, 32'd0);
    end
  endtask

  // Monitor: every strobe must match the oldest expected code.
  initial begin
    strobes = 0;
    forever begin
      @(negedge clock);
      if (number_valid === 1'b1) begin
        strobes++;
        if (exp_q.size() == 0) begin
          chk("spurious_strobe", {31'd0, number_valid}, 32'd0);
        end else begin
          chk("strobe_code", {28'd0, number}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    tb_keys  = K_NONE;
    reset_n  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Test 1: reset mid-scan, then column rotation
    repeat (7) @(negedge clock);
    chk("col_mid_scan", {28'd0, col_out}, {28'd0, 4'b1101});
    reset_n = 1'b0;
    #1;
    chk("rst_col", {28'd0, col_out}, {28'd0, 4'b1110});
    chk("rst_number", {28'd0, number}, 32'd0);
    chk("rst_valid", {31'd0, number_valid}, 32'd0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("rot_c0", {28'd0, col_out}, {28'd0, 4'b1110});
    repeat (4) @(negedge clock);
    chk("rot_c1", {28'd0, col_out}, {28'd0, 4'b1101});
    repeat (4) @(negedge clock);
    chk("rot_c2", {28'd0, col_out}, {28'd0, 4'b1011});
    repeat (4) @(negedge clock);
    chk("rot_c3", {28'd0, col_out}, {28'd0, 4'b0111});
    repeat (4) @(negedge clock);
    chk("rot_wrap", {28'd0, col_out}, {28'd0, 4'b1110});

    // Test 2: single press of '1'
    frames(K_1, 1);
    chk("p1_no_early", {31'd0, number_valid}, 32'd0);
    exp_q.push_back(4'h1);
    frames(K_1, 1);
    chk("p1_strobe", {31'd0, number_valid}, 32'd1);
    chk("p1_number", {28'd0, number}, 32'h1);
    chk("p1_held", {31'd0, key_held}, 32'd1);
    frames(K_1, 1);
    chk("p1_one_shot", {31'd0, number_valid}, 32'd0);
    frames(K_NONE, 1);
    chk("p1_held_rel1", {31'd0, key_held}, 32'd1);
    frames(K_NONE, 1);
    chk("p1_released", {31'd0, key_held}, 32'd0);
    chk("p1_number_hold", {28'd0, number}, 32'h1);
    frames(K_NONE, 1);

    // Test 3: sequence 1, 0, 9, 4
    frames(K_1, 1); exp_q.push_back(4'h1); frames(K_1, 2); frames(K_NONE, 3);
    frames(K_0, 1); exp_q.push_back(4'h0); frames(K_0, 2); frames(K_NONE, 3);
    chk("seq_after_0", {28'd0, number}, 32'h0);
    frames(K_9, 1); exp_q.push_back(4'h9); frames(K_9, 2); frames(K_NONE, 3);
    chk("seq_after_9", {28'd0, number}, 32'h9);
    frames(K_4, 1); exp_q.push_back(4'h4); frames(K_4, 2); frames(K_NONE, 3);
    chk("seq_after_4", {28'd0, number}, 32'h4);
    chk("seq_strobes", strobes, 32'd5);

    // Test 4: bounce, then release glitch
    frames(K_5, 1);
    frames(K_NONE, 2);
    chk("bounce_no_strobe", strobes, 32'd5);
    frames(K_5, 1); exp_q.push_back(4'h5); frames(K_5, 1);
    frames(K_NONE, 1);
    frames(K_5, 2);
    chk("glitch_held", {31'd0, key_held}, 32'd1);
    frames(K_NONE, 3);
    chk("glitch_one_strobe", strobes, 32'd6);
    chk("glitch_number", {28'd0, number}, 32'h5);

    // Test 5: multi-key, then reset during debounce of '7'
    frames(K_2 | K_8, 3);
    chk("multi_no_strobe", strobes, 32'd6);
    frames(K_7, 1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    tb_keys = K_NONE;
    #1;
    chk("abort_number", {28'd0, number}, 32'd0);
    chk("abort_col", {28'd0, col_out}, {28'd0, 4'b1110});
    @(negedge clock);
    reset_n = 1'b1;
    frames(K_NONE, 3);
    chk("abort_no_strobe", strobes, 32'd6);
    chk("abort_held", {31'd0, key_held}, 32'd0);

    // Test 6: hold '#' for 9 frames
    strobes_before = strobes;
`ifdef KEYPAD_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 1;
`endif
    for (int f = 1; f <= 9; f++) begin
      if (f == 2) exp_q.push_back(4'hF);
`ifdef KEYPAD_REPEAT_EN
      if (f == 5 || f == 8) exp_q.push_back(4'hF);
`endif
      frames(K_HASH, 1);
    end
    chk("hash_number", {28'd0, number}, 32'hF);
    frames(K_NONE, 3);
    chk("hash_strobes", strobes - strobes_before, exp_rep);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
